// File: rtl/hud_pkg.sv
// Shared HUD geometry, sprite selectors and renderer state encoding.
// Used by the heart renderer and the other screen drawers.
package hud_pkg;

  localparam int SCREEN_W   = 640;
  localparam int ADDR_W     = 19;
  localparam int COLOR_W    = 8;
  localparam int HEART_W    = 16;
  localparam int HEART_H    = 16;
  localparam int HEART_GAP  = 2;
  localparam int MAX_HEARTS = 5;
  localparam int HUD_X      = 8;
  localparam int HUD_Y      = 8;

  localparam logic [COLOR_W-1:0] TRANSP = 8'h00;

  localparam int SPRITE_PIX = HEART_W * HEART_H;
  localparam int ROM_ADDR_W = $clog2(2 * SPRITE_PIX);
  localparam int X_W        = $clog2(HEART_W);
  localparam int Y_W        = $clog2(HEART_H);
  localparam int SLOT_W     = $clog2(MAX_HEARTS);
  localparam int HP_W       = 3;

  localparam logic SPR_FULL  = 1'b0;
  localparam logic SPR_EMPTY = 1'b1;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    FETCH   = 3'd1,
    WRITE   = 3'd2,
    DONE    = 3'd3,
    RELEASE = 3'd4
  } hud_state_e;

  function automatic logic [HP_W-1:0] clamp_hp(input logic [HP_W-1:0] hp);
    return (hp > HP_W'(MAX_HEARTS)) ? HP_W'(MAX_HEARTS) : hp;
  endfunction

endpackage

// File: rtl/hud_slot_counter.sv
// Nested pixel/row/slot counter walking every heart slot in raster order.
module hud_slot_counter
  import hud_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clear,
  input  logic              advance,
  output logic [X_W-1:0]    x,
  output logic [Y_W-1:0]    y,
  output logic [SLOT_W-1:0] slot,
  output logic              last
);

  logic x_last, y_last, slot_last;

  assign x_last    = (x == X_W'(HEART_W - 1));
  assign y_last    = (y == Y_W'(HEART_H - 1));
  assign slot_last = (slot == SLOT_W'(MAX_HEARTS - 1));
  assign last      = x_last && y_last && slot_last;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x    <= '0;
      y    <= '0;
      slot <= '0;
    end else if (clear) begin
      x    <= '0;
      y    <= '0;
      slot <= '0;
    end else if (advance) begin
      if (x_last) begin
        x <= '0;
        if (y_last) begin
          y    <= '0;
          slot <= slot_last ? '0 : slot + 1'b1;
        end else begin
          y <= y + 1'b1;
        end
      end else begin
        x <= x + 1'b1;
      end
    end
  end

endmodule

// File: rtl/hud_heart_renderer.sv
// Draws the health hearts into the frame buffer during the sequencer's HUD phase.
//
// state   | meaning
// IDLE    | waiting for DrawHudEN, latches clamped health on start
// FETCH   | rom_addr presented for the current pixel
// WRITE   | rom_data valid; write opaque pixel, hold until fb_ready
// DONE    | one-cycle DrawHudDone pulse
// RELEASE | wait for DrawHudEN low so one enable level draws once
module hud_heart_renderer
  import hud_pkg::*;
(
  input  logic                  CLK,
  input  logic                  RESET_N,
  input  logic                  DrawHudEN,
  input  logic [HP_W-1:0]       PlayerHealth,
  output logic [ROM_ADDR_W-1:0] rom_addr,
  input  logic [COLOR_W-1:0]    rom_data,
  output logic [ADDR_W-1:0]     fb_addr,
  output logic [COLOR_W-1:0]    fb_data,
  output logic                  fb_we,
  input  logic                  fb_ready,
  output logic                  DrawHudDone
);

  localparam logic [2:0] ST_IDLE    = IDLE;
  localparam logic [2:0] ST_FETCH   = FETCH;
  localparam logic [2:0] ST_WRITE   = WRITE;
  localparam logic [2:0] ST_DONE    = DONE;
  localparam logic [2:0] ST_RELEASE = RELEASE;

  logic [2:0]              state, state_nxt;
  logic [HP_W-1:0]         hp;
  logic                    hold;
  logic [COLOR_W-1:0]      pix_q;
  logic [X_W-1:0]          x;
  logic [Y_W-1:0]          y;
  logic [SLOT_W-1:0]       slot;
  logic                    cnt_clear, cnt_adv, cnt_last;
  logic                    sel, opaque, step;
  logic [COLOR_W-1:0]      pix;
  logic [ROM_ADDR_W-1:0]   rom_addr_calc;
  logic [ADDR_W-1:0]       fb_addr_calc;

  hud_slot_counter u_cnt (
    .clk     (CLK),
    .rst_n   (RESET_N),
    .clear   (cnt_clear),
    .advance (cnt_adv),
    .x       (x),
    .y       (y),
    .slot    (slot),
    .last    (cnt_last)
  );

  assign sel = (ADDR_W'(slot) < ADDR_W'(hp)) ? SPR_FULL : SPR_EMPTY;

  assign rom_addr_calc = ((sel == SPR_EMPTY) ? ROM_ADDR_W'(SPRITE_PIX) : '0)
                       + ROM_ADDR_W'(y) * ROM_ADDR_W'(HEART_W)
                       + ROM_ADDR_W'(x);

  assign fb_addr_calc = ADDR_W'(HUD_Y * SCREEN_W + HUD_X)
                      + ADDR_W'(y) * ADDR_W'(SCREEN_W)
                      + ADDR_W'(slot) * ADDR_W'(HEART_W + HEART_GAP)
                      + ADDR_W'(x);

  // ROM output moves on once rom_addr leaves FETCH, so a stalled write replays the captured pixel.
  assign pix    = hold ? pix_q : rom_data;
  assign opaque = (pix != TRANSP);
  assign step   = !opaque || fb_ready;

  assign rom_addr    = (state == ST_FETCH) ? rom_addr_calc : '0;
  assign fb_we       = (state == ST_WRITE) && opaque;
  assign fb_addr     = (state == ST_WRITE) ? fb_addr_calc : '0;
  assign fb_data     = (state == ST_WRITE) ? pix : '0;
  assign DrawHudDone = (state == ST_DONE);

  always_comb begin
    state_nxt = state;
    cnt_clear = 1'b0;
    cnt_adv   = 1'b0;
    case (state)
      ST_IDLE: begin
        if (DrawHudEN) begin
          state_nxt = ST_FETCH;
          cnt_clear = 1'b1;
        end
      end
      ST_FETCH: state_nxt = DrawHudEN ? ST_WRITE : ST_IDLE;
      ST_WRITE: begin
        if (!DrawHudEN) begin
          state_nxt = ST_IDLE;
        end else if (step) begin
          cnt_adv   = 1'b1;
          state_nxt = cnt_last ? ST_DONE : ST_FETCH;
        end
      end
      ST_DONE:    state_nxt = ST_RELEASE;
      ST_RELEASE: if (!DrawHudEN) state_nxt = ST_IDLE;
      default:    state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state <= ST_IDLE;
      hp    <= '0;
      hold  <= 1'b0;
      pix_q <= '0;
    end else begin
      state <= state_nxt;
      if (state == ST_IDLE && DrawHudEN) hp <= clamp_hp(PlayerHealth);
      if (state == ST_WRITE && state_nxt == ST_WRITE) begin
        hold  <= 1'b1;
        pix_q <= pix;
      end else begin
        hold  <= 1'b0;
      end
    end
  end

endmodule
